// File: rtl/sample_voice_mixer.sv
// Per tick, reads 8 voices from the shared bank, sums the gated ones and emits one saturated sample; result 9+READ_LATENCY cycles after the tick.
// No backpressure: a tick arriving mid-mix is dropped and flagged on overrun one cycle later.
module sample_voice_mixer #(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int MIX_SHIFT    = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    sample_tick,
    input  logic [7:0]              gate_in,
    input  logic [ADDR_WIDTH-1:0]   sample_addr,
    output logic [ADDR_WIDTH+2:0]   bram_addr,
    input  logic [DATA_WIDTH-1:0]   bram_data,
    output logic [DATA_WIDTH-1:0]   mix_out,
    output logic                    mix_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int ACC_WIDTH = DATA_WIDTH + 3;
    localparam int LAT       = READ_LATENCY;
    localparam int DCW       = $clog2(LAT + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0]        addr_lat;
    logic [7:0]                   gate_lat;
    logic [2:0]                   voice;
    logic [2:0]                   voice_inc;
    logic [DCW-1:0]               drain_cnt;
    logic [LAT:0]                 tag_vld;
    logic [LAT:0]                 tag_gate;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  data_ext;
    logic signed [ACC_WIDTH-1:0]  contrib;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]        mix_sat;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {4'b0000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {4'b1111, {(DATA_WIDTH-1){1'b0}}};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = ISSUE;
            ISSUE:   if (voice == 3'd7) state_next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tag stage LAT lines up with the bank data for the same voice.
    always_comb begin
        voice_inc = voice + 3'd1;
        data_ext  = {{3{bram_data[DATA_WIDTH-1]}}, bram_data};
        contrib   = (tag_vld[LAT] && tag_gate[LAT]) ? data_ext : '0;
        acc_next  = acc + contrib;
        shifted   = acc_next >>> MIX_SHIFT;
        if (shifted > SAT_MAX) begin
            mix_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            mix_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            mix_sat = shifted[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_lat  <= '0;
            gate_lat  <= '0;
            voice     <= '0;
            drain_cnt <= '0;
            tag_vld   <= '0;
            tag_gate  <= '0;
            acc       <= '0;
            bram_addr <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun   <= sample_tick && (state != IDLE);
            mix_valid <= 1'b0;
            acc       <= acc_next;
            for (int i = 1; i <= LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_gate[i] <= tag_gate[i-1];
            end
            tag_vld[0]  <= 1'b0;
            tag_gate[0] <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        addr_lat    <= sample_addr;
                        gate_lat    <= gate_in;
                        acc         <= '0;
                        voice       <= 3'd0;
                        bram_addr   <= {3'd0, sample_addr};
                        tag_vld[0]  <= 1'b1;
                        tag_gate[0] <= gate_in[0];
                    end
                end
                ISSUE: begin
                    if (voice != 3'd7) begin
                        voice       <= voice_inc;
                        bram_addr   <= {voice_inc, addr_lat};
                        tag_vld[0]  <= 1'b1;
                        tag_gate[0] <= gate_lat[voice_inc];
                    end else begin
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    // The last voice lands this cycle, so saturate the updated sum directly.
                    if (drain_cnt == DRAIN_LAST) begin
                        mix_out   <= mix_sat;
                        mix_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
